// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      HALT     = 2'd2
   } pipe_state_t;

   localparam int STAGE_N   = 4;
   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;

   function automatic logic [STAGE_N-1:0] stg_bit(input int idx);
      stg_bit = {{(STAGE_N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_stall_timer.sv
// Loadable down-counter that times the multiply/divide freeze; zero marks the release cycle.
module mdu_stall_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Load wins over hold so an accept cycle always arms the timer; the count saturates at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (!hold && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage buffer write enables/clears and PC write enable.
// Define PIPE_PERF_EN to build the stall/flush performance counters; otherwise they read as 0.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_LAT = 32,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_use,
   input  logic               branch_taken,
   input  logic               mem_busy,
   input  logic               mdu_start,
   input  logic               halt_req,
   input  logic               resume,
   output logic               pc_we,
   output logic [STAGE_N-1:0] stage_we,
   output logic [STAGE_N-1:0] stage_clr,
   output logic               halted,
   output logic               mdu_busy,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
);

   localparam logic [CNT_W-1:0]   MDU_LOAD   = CNT_W'(MDU_LAT - 1);
   localparam logic [STAGE_N-1:0] ALL_MASK   = stg_bit(STG_IFID) | stg_bit(STG_IDEX) |
                                               stg_bit(STG_EXMEM) | stg_bit(STG_MEMWB);
   localparam logic [STAGE_N-1:0] MDU_MASK   = stg_bit(STG_MEMWB);
   localparam logic [STAGE_N-1:0] FLUSH_MASK = stg_bit(STG_IFID) | stg_bit(STG_IDEX);

   pipe_state_t state, state_next;
   logic        cnt_zero;
   logic        mdu_accept;
   logic        mdu_freeze;
   logic        halt_freeze;

   assign mdu_accept  = (state == RUN) && mdu_start && !mem_busy;
   assign mdu_freeze  = ((state == MDU_WAIT) && !cnt_zero) || ((state == RUN) && mdu_start);
   assign halt_freeze = (state == HALT) || ((state == RUN) && halt_req);

   mdu_stall_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (mdu_accept),
      .load_val (MDU_LOAD),
      .hold     (mem_busy),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // A mem_busy cycle freezes everything, including the FSM.
   always_comb begin
      state_next = state;
      if (!mem_busy) begin
         unique case (state)
            RUN: begin
               if (mdu_start) begin
                  state_next = MDU_WAIT;
               end else if (halt_req) begin
                  state_next = HALT;
               end
            end
            MDU_WAIT: begin
               if (cnt_zero) begin
                  state_next = RUN;
               end
            end
            HALT: begin
               if (resume) begin
                  state_next = RUN;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // The MDU release cycle falls through to the normal branch/load-use rules.
   always_comb begin
      pc_we     = 1'b0;
      stage_we  = '0;
      stage_clr = '0;
      halted    = 1'b0;
      mdu_busy  = 1'b0;
      if (!reset) begin
         stage_we  = ALL_MASK;
         stage_clr = ALL_MASK;
      end else begin
         halted   = (state == HALT);
         mdu_busy = (state == MDU_WAIT) || mdu_accept;
         if (mem_busy) begin
            pc_we = 1'b0;
         end else if (mdu_freeze) begin
            stage_we  = MDU_MASK;
            stage_clr = MDU_MASK;
         end else if (halt_freeze) begin
            pc_we = 1'b0;
         end else if (branch_taken) begin
            pc_we     = 1'b1;
            stage_we  = ALL_MASK;
            stage_clr = FLUSH_MASK;
         end else if (load_use) begin
            stage_we  = ALL_MASK & ~stg_bit(STG_IFID);
            stage_clr = stg_bit(STG_IDEX);
         end else begin
            pc_we    = 1'b1;
            stage_we = ALL_MASK;
         end
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   // Halt cycles are deliberately idle time, not stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_we && (state != HALT)) begin
            stall_q <= stall_q + 32'd1;
         end
         if (stage_clr[STG_IFID]) begin
            flush_q <= flush_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the CPU's four inter-stage buffer banks (IF/ID, ID/EX, EX/MEM, MEM/WB), each an 8×32-bit `regBuf` with a shared write enable and a clear. It turns the hazard, branch, memory-wait, multiply/divide and halt requests into per-stage write enables and bubble-insert clears, plus the PC write enable. It sits beside the datapath top and drives the `WE` and `reset` inputs of every `regBuf` instance.

## Interface
- `MDU_LAT`, default 32: total freeze cycles per multiply/divide op; legal range 1..255.
- `CNT_W`, default 8: width of the MDU stall counter; must hold `MDU_LAT-1`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous reset, active-low.
- `load_use`  in  1  load-use hazard detected in ID.
- `branch_taken`  in  1  taken branch or jump resolved in EX.
- `mem_busy`  in  1  data memory not ready; whole pipe must hold.
- `mdu_start`  in  1  multiply/divide op in EX; single-cycle pulse.
- `halt_req`  in  1  syscall-halt instruction in MEM/WB.
- `resume`  in  1  leave HALT; single-cycle pulse.
- `pc_we`  out  1  PC write enable.
- `stage_we`  out  4  buffer write enables; [0]=IF/ID … [3]=MEM/WB.
- `stage_clr`  out  4  buffer clears; `stage_clr[i]` always implies `stage_we[i]`.
- `halted`  out  1  high in HALT.
- `mdu_busy`  out  1  high in the MDU accept cycle and throughout MDU_WAIT.
- `stall_cnt`  out  32  PC-stall cycle count; see Configuration.
- `flush_cnt`  out  32  branch-flush cycle count; see Configuration.

## Operation
- States: RUN, MDU_WAIT, HALT. The reset state is RUN.
- Outputs are combinational from the current state and the inputs.
- Per-cycle priority, highest first:
  - **`mem_busy`:** `pc_we=0`, `stage_we=0000`, `stage_clr=0000`. No state change. The MDU counter holds.
  - **MDU_WAIT, or RUN with `mdu_start`:** `pc_we=0`, `stage_we=1000`, `stage_clr=1000`, which sends a bubble into MEM/WB.
  - **HALT:** `pc_we=0`, `stage_we=0000`.
  - **`branch_taken`:** `pc_we=1`, `stage_we=1111`, `stage_clr=0011`. This branch wins over a simultaneous `load_use`.
  - **`load_use`:** `pc_we=0`, `stage_we=1110`, `stage_clr=0010`.
  - **Otherwise:** `pc_we=1`, `stage_we=1111`, `stage_clr=0000`.
- State transitions:
  - **RUN to MDU_WAIT:** on `mdu_start` and not `mem_busy`. The counter loads `MDU_LAT-1`. If `MDU_LAT=1`, the counter loads 0.
  - **MDU_WAIT:** with the counter non-zero and not `mem_busy`, the counter decrements. When the counter is 0, that cycle is a release cycle: RUN priority rules apply and the state goes to RUN.
  - **RUN to HALT:** on `halt_req` and not `mem_busy` and not `mdu_start`. The halt cycle itself already freezes the pipe.
  - **HALT to RUN:** on `resume`.
- Ignored inputs:
  - `mdu_start` outside RUN.
  - `halt_req` in MDU_WAIT or HALT.
  - `resume` outside HALT.
  - `branch_taken` and `load_use` during freeze. Upstream holds them, so they re-evaluate on release.
- Reset, asserted at any time (including mid-MDU_WAIT or HALT):
  - State goes to RUN, the counter and the perf counters go to 0.
  - While `reset` is low, outputs are forced to `stage_we=1111`, `stage_clr=1111`, `pc_we=0`, `halted=0`, `mdu_busy=0`.

## Timing
- Zero-latency control: hazard inputs affect outputs in the same cycle.
- MDU: with `mdu_start` in cycle T and no `mem_busy`, cycles T..T+MDU_LAT-1 are frozen and cycle T+MDU_LAT is the release cycle. Each `mem_busy` cycle extends the freeze by one.
- HALT: `halt_req` at T freezes from T on. `resume` at R makes R+1 a normal RUN cycle.
- First cycle after `reset` deasserts: RUN with normal priority rules.

## Configuration
- **`PIPE_PERF_EN` defined:**
  - `stall_cnt` increments in every cycle with `pc_we=0` while `reset` is high and the state is not HALT.
  - `flush_cnt` increments in every cycle where `stage_clr[0]` is 1 and `reset` is high.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- **`PIPE_PERF_EN` undefined:** no counter flops; both ports are tied to 0.

## Structure
- Package `pipe_ctrl_pkg`:
  - state enum `pipe_state_t` (RUN, MDU_WAIT, HALT);
  - stage index constants `STG_IFID=0`, `STG_IDEX=1`, `STG_EXMEM=2`, `STG_MEMWB=3`;
  - `STAGE_N=4`.
- One sub-module, `mdu_stall_timer`: loadable down-counter with a hold input and a zero flag, parameterised by `CNT_W`.

## Test plan
- **Reset:** hold `reset` low for 3 cycles → `stage_we=1111`, `stage_clr=1111`, `pc_we=0`. After release with no requests → `pc_we=1`, `stage_we=1111`, `stage_clr=0000`.
- **Branch vs load-use:** `load_use` alone → `pc_we=0`, `stage_we=1110`, `stage_clr=0010`. `load_use` and `branch_taken` together → `pc_we=1`, `stage_clr=0011`, and `flush_cnt` +1 when `PIPE_PERF_EN` is defined.
- **MDU freeze:** with `MDU_LAT=4`, `mdu_start` at T → cycles T..T+3 give `stage_we=1000`, `stage_clr=1000`, `mdu_busy=1`; T+4 is the release cycle. Adding `mem_busy` at T+2 for 2 cycles moves the release to T+6, with `stage_we=0000` on those 2 cycles.
- **Halt:** `halt_req` → `halted=1` and everything frozen for 10 cycles. `resume` → the next cycle is normal. A `resume` sent while in RUN has no effect.
- **Reset mid-MDU:** assert `reset` during MDU_WAIT with the counter at 2 → after release, state is RUN and `mdu_busy=0`.
- **Perf counter:** with `PIPE_PERF_EN` defined, 5 `load_use` cycles plus a `MDU_LAT=4` op → `stall_cnt=9`. With it undefined → `stall_cnt=0`.
